// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Pipelined immediate generator for the decode stage.
//            The block takes instruction bits [31:7] and a format select
//            over a valid/ready handshake. It builds the sign- or
//            zero-extended immediate combinationally. It registers that
//            result into a small circular output FIFO, so a result shows
//            one cycle after it is accepted.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   XLEN   output immediate width (32 or 64)
//   TAG_W  width of the sideband tag carried alongside each result
//   DEPTH  output buffer entries (2 or 4)
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous drop of all entries and any same-cycle push
//   in_valid     request valid
//   in_ready     buffer not full (registered, no pop-through)
//   inst_31_7    instruction bits [31:7]
//   imm_sel      format select (I=0, S=1, B=2, U=3, J=4, ZIMM=7 optional)
//   in_tag       sideband tag
//   out_valid    head entry valid
//   out_ready    consumer accepts head entry
//   imm          head immediate (0 when no entry is valid)
//   out_tag      head tag (0 when no entry is valid)
//   out_fmt_err  head entry had an unsupported select
// Build option
//   IMM_GEN_ZIMM_EN  when defined, select 3'd7 yields the CSR zimm field
//                    zero-extended. Otherwise 3'd7 is unsupported.
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      inst_31_7,
  input  logic [2:0]       imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_fmt_err
);

  // Format select codes, matching the rv32 decode definitions.
  localparam logic [2:0] SEL_I    = 3'd0;
  localparam logic [2:0] SEL_S    = 3'd1;
  localparam logic [2:0] SEL_B    = 3'd2;
  localparam logic [2:0] SEL_U    = 3'd3;
  localparam logic [2:0] SEL_J    = 3'd4;
`ifdef IMM_GEN_ZIMM_EN
  localparam logic [2:0] SEL_ZIMM = 3'd7;
`endif

  localparam int             PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Immediate formation
  // --------------------------------------------------------------------------
  // Index the slice with real instruction bit numbers to keep the
  // format equations readable.
  logic [31:7]     inst_w;
  logic [31:0]     imm32_w;
  logic            fmt_err_w;
  logic [XLEN-1:0] imm_ext_w;

  assign inst_w = inst_31_7;

  always_comb begin
    imm32_w   = '0;
    fmt_err_w = 1'b0;
    case (imm_sel)
      SEL_I: imm32_w = {{20{inst_w[31]}}, inst_w[31:20]};
      SEL_S: imm32_w = {{20{inst_w[31]}}, inst_w[31:25], inst_w[11:7]};
      SEL_B: imm32_w = {{19{inst_w[31]}}, inst_w[31], inst_w[7],
                        inst_w[30:25], inst_w[11:8], 1'b0};
      SEL_U: imm32_w = {inst_w[31:12], 12'b0};
      SEL_J: imm32_w = {{11{inst_w[31]}}, inst_w[31], inst_w[19:12],
                        inst_w[20], inst_w[30:21], 1'b0};
`ifdef IMM_GEN_ZIMM_EN
      SEL_ZIMM: imm32_w = {27'b0, inst_w[19:15]};
`endif
      default: begin
        imm32_w   = '0;
        fmt_err_w = 1'b1;
      end
    endcase
  end

  // Every format is already correct at 32 bits. Widening to XLEN is a
  // plain sign extension of bit 31. For zimm, bit 31 is 0, so the same
  // extension acts as a zero extension.
  assign imm_ext_w = XLEN'($signed(imm32_w));

  // --------------------------------------------------------------------------
  // Output FIFO control
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push_w;
  logic             pop_w;
  logic             ready_w;
  logic             valid_w;

  assign ready_w = (count_q != CNT_FULL);
  assign valid_w = (count_q != '0);

  // Flush overrides both sides. Gating push and pop here keeps the
  // storage write and pointer updates consistent in a flush cycle.
  assign push_w = in_valid & ready_w & ~flush;
  assign pop_w  = valid_w & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow wraps naturally.
      if (push_w) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_w) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push_w, pop_w})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Entry storage (no reset: contents are only observed while valid)
  // --------------------------------------------------------------------------
  logic [XLEN-1:0]  imm_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];
  logic             err_mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (push_w) begin
      imm_mem_q[wr_ptr_q] <= imm_ext_w;
      tag_mem_q[wr_ptr_q] <= in_tag;
      err_mem_q[wr_ptr_q] <= fmt_err_w;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: driven only from registered state
  // --------------------------------------------------------------------------
  // The head entry is never overwritten while it waits, because a full
  // buffer blocks pushes. The head therefore holds stable under
  // backpressure. Masking with valid makes all outputs read zero as soon
  // as reset asserts, without waiting for a clock edge.
  assign in_ready    = ready_w;
  assign out_valid   = valid_w;
  assign imm         = valid_w ? imm_mem_q[rd_ptr_q] : '0;
  assign out_tag     = valid_w ? tag_mem_q[rd_ptr_q] : '0;
  assign out_fmt_err = valid_w & err_mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Purpose  : Self-checking bench for imm_gen_pipe.
//            Two instances (XLEN=32 and XLEN=64, DEPTH=2) share one
//            stimulus stream. A queue-based reference model computes
//            immediates with plain integer arithmetic from the format rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

  localparam int TAG_W = 5;
  localparam int DEPTH = 2;

  localparam logic [2:0] C_I = 3'd0;
  localparam logic [2:0] C_S = 3'd1;
  localparam logic [2:0] C_B = 3'd2;
  localparam logic [2:0] C_U = 3'd3;
  localparam logic [2:0] C_J = 3'd4;
  localparam logic [2:0] C_Z = 3'd7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             out_ready;
  logic [31:0]      cur_inst;
  logic [24:0]      inst_31_7;
  logic [2:0]       imm_sel;
  logic [TAG_W-1:0] in_tag;

  logic             rdy32, vld32, err32;
  logic [31:0]      imm32;
  logic [TAG_W-1:0] tag32;
  logic             rdy64, vld64, err64;
  logic [63:0]      imm64;
  logic [TAG_W-1:0] tag64;

  int n_checks = 0;
  int n_errors = 0;

  assign inst_31_7 = cur_inst[31:7];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .DEPTH(DEPTH)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32),
    .inst_31_7(inst_31_7), .imm_sel(imm_sel), .in_tag(in_tag),
    .out_valid(vld32), .out_ready(out_ready),
    .imm(imm32), .out_tag(tag32), .out_fmt_err(err32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W), .DEPTH(DEPTH)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .inst_31_7(inst_31_7), .imm_sel(imm_sel), .in_tag(in_tag),
    .out_valid(vld64), .out_ready(out_ready),
    .imm(imm64), .out_tag(tag64), .out_fmt_err(err64)
  );

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  typedef struct {
    logic [63:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } ent_t;

  ent_t mq[$];
  ent_t ne;
  bit   m_push, m_pop;

  // Assemble the field value as a non-negative integer. Then fold it into
  // the signed range of its bit width.
  function automatic void ref_imm(input logic [31:0] ins, input logic [2:0] sel,
                                  output logic [63:0] im, output logic er);
    longint v;
    v  = 0;
    er = 1'b0;
    case (sel)
      C_I: begin
        v = longint'(ins[31:20]);
        if (v >= 2048) v = v - 4096;
      end
      C_S: begin
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (v >= 2048) v = v - 4096;
      end
      C_B: begin
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (v >= 4096) v = v - 8192;
      end
      C_U: begin
        v = longint'(ins) - longint'(ins[11:0]);
        if (v >= 64'sh8000_0000) v = v - 64'sh1_0000_0000;
      end
      C_J: begin
        v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
          + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (v >= 1048576) v = v - 2097152;
      end
`ifdef IMM_GEN_ZIMM_EN
      C_Z: v = longint'(ins[19:15]);
`endif
      default: begin
        v  = 0;
        er = 1'b1;
      end
    endcase
    im = 64'(v);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      m_pop  = (mq.size() != 0) && out_ready;
      m_push = in_valid && (mq.size() != DEPTH);
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        ref_imm(cur_inst, imm_sel, ne.imm, ne.err);
        ne.tag = in_tag;
        mq.push_back(ne);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  logic e_v, e_r;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      e_v = (mq.size() != 0);
      e_r = (mq.size() != DEPTH);
      chk("m_out_valid32", 64'(vld32), 64'(e_v));
      chk("m_out_valid64", 64'(vld64), 64'(e_v));
      chk("m_in_ready32", 64'(rdy32), 64'(e_r));
      chk("m_in_ready64", 64'(rdy64), 64'(e_r));
      if (e_v) begin
        chk("m_imm32", 64'(imm32), 64'(mq[0].imm[31:0]));
        chk("m_imm64", imm64, mq[0].imm);
        chk("m_tag32", 64'(tag32), 64'(mq[0].tag));
        chk("m_tag64", 64'(tag64), 64'(mq[0].tag));
        chk("m_err32", 64'(err32), 64'(mq[0].err));
        chk("m_err64", 64'(err64), 64'(mq[0].err));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] sel,
                       input logic [TAG_W-1:0] tag);
    in_valid = v;
    cur_inst = ins;
    imm_sel  = sel;
    in_tag   = tag;
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_valid32"}, 64'(vld32), 64'd0);
    chk({name, "_valid64"}, 64'(vld64), 64'd0);
    chk({name, "_imm32"}, 64'(imm32), 64'd0);
    chk({name, "_imm64"}, imm64, 64'd0);
    chk({name, "_tag"}, 64'(tag32), 64'd0);
    chk({name, "_err"}, 64'(err32), 64'd0);
  endtask

  logic [63:0] p_imm;
  logic        p_err;

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, C_I, '0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 64'(rdy32), 64'd1);

    // Pin the model against hand-computed values
    ref_imm(32'hFE000EE3, C_B, p_imm, p_err);
    chk("pin_B", p_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    ref_imm(32'h800000B7, C_U, p_imm, p_err);
    chk("pin_U_neg", p_imm, 64'hFFFF_FFFF_8000_0000);
    ref_imm(32'hFFF00093, C_I, p_imm, p_err);
    chk("pin_I", p_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    ref_imm(32'h00000000, 3'd5, p_imm, p_err);
    chk("pin_bad_sel_err", 64'(p_err), 64'd1);

    // I format, one-cycle latency
    step;
    drive(1'b1, 32'hFFF00093, C_I, 5'd1);
    step;
    in_valid = 1'b0;
    @(negedge clk);
    chk("I_valid", 64'(vld32), 64'd1);
    chk("I_imm32", 64'(imm32), 64'h0000_0000_FFFF_FFFF);
    chk("I_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("I_err", 64'(err32), 64'd0);

    // B format
    drive(1'b1, 32'hFE000EE3, C_B, 5'd2);
    step;
    in_valid = 1'b0;
    @(negedge clk);
    chk("B_imm32", 64'(imm32), 64'h0000_0000_FFFF_FFFC);

    // U format, negative and positive
    drive(1'b1, 32'h800000B7, C_U, 5'd3);
    step;
    in_valid = 1'b0;
    @(negedge clk);
    chk("U_neg_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    chk("U_neg_imm32", 64'(imm32), 64'h0000_0000_8000_0000);
    drive(1'b1, 32'h123450B7, C_U, 5'd4);
    step;
    in_valid = 1'b0;
    @(negedge clk);
    chk("U_pos_imm32", 64'(imm32), 64'h0000_0000_1234_5000);
    chk("U_pos_imm64", imm64, 64'h0000_0000_1234_5000);

    // Select 3'd7 with inst[19:15] = 5'h1F
    drive(1'b1, 32'h000F8073, C_Z, 5'd5);
    step;
    in_valid = 1'b0;
    @(negedge clk);
`ifdef IMM_GEN_ZIMM_EN
    chk("zimm_imm", imm64, 64'h1F);
    chk("zimm_err", 64'(err64), 64'd0);
`else
    chk("sel7_imm", imm64, 64'h0);
    chk("sel7_err", 64'(err64), 64'd1);
`endif

    // Backpressure: tags 1,2,3 with the consumer stalled
    step;
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, C_I, 5'd1);
    step;
    drive(1'b1, 32'h00200093, C_I, 5'd2);
    step;
    drive(1'b1, 32'h00300093, C_I, 5'd3);
    @(negedge clk);
    chk("bp_full_in_ready", 64'(rdy32), 64'd0);
    chk("bp_head_tag1", 64'(tag32), 64'd1);
    step;
    @(negedge clk);
    chk("bp_stall_tag1", 64'(tag32), 64'd1);
    chk("bp_stall_imm", 64'(imm32), 64'd1);
    out_ready = 1'b1;
    step;
    @(negedge clk);
    chk("bp_pop_tag2", 64'(tag32), 64'd2);
    chk("bp_pop_valid2", 64'(vld32), 64'd1);
    step;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_pop_tag3", 64'(tag32), 64'd3);
    chk("bp_pop_valid3", 64'(vld32), 64'd1);
    step;
    @(negedge clk);
    chk("bp_drained", 64'(vld32), 64'd0);

    // Flush with a full buffer and a same-cycle push
    out_ready = 1'b0;
    drive(1'b1, 32'h00A00093, C_I, 5'd10);
    step;
    drive(1'b1, 32'h00B00093, C_I, 5'd11);
    step;
    drive(1'b1, 32'h00C00093, C_I, 5'd12);
    flush = 1'b1;
    step;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(vld32), 64'd0);
    chk("flush_in_ready", 64'(rdy32), 64'd1);
    step;
    @(negedge clk);
    chk("flush_still_empty", 64'(vld64), 64'd0);

    // Asynchronous reset with two entries buffered
    drive(1'b1, 32'hFFF00093, C_I, 5'd20);
    step;
    drive(1'b1, 32'h80000037, C_U, 5'd21);
    step;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", 64'(vld32), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 64'(rdy32), 64'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      cur_inst  = $urandom();
      imm_sel   = 3'($urandom_range(0, 7));
      in_tag    = TAG_W'($urandom());
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 31) == 0);
      step;
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) step;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
